// File: rtl/fft_frame_sequencer_pkg.sv
// Shared types and constants for the 16-point FFT front end and datapath.
// The sequencer state encoding and default frame geometry live here.
package fft_frame_sequencer_pkg;

   localparam int WIDTH_DEF   = 12;
   localparam int N_DEF       = 16;
   localparam int TIMEOUT_DEF = 8;

   typedef enum logic [1:0] {IDLE, START, WAIT} seq_state_t;

   // First-quadrant W16^k = cos - j*sin for k = 0..3, Q1.10; other powers follow by symmetry
   localparam int TW_W = 12;
   localparam logic signed [TW_W-1:0] TW_COS [4] = '{12'sd1024, 12'sd946, 12'sd724, 12'sd392};
   localparam logic signed [TW_W-1:0] TW_SIN [4] = '{12'sd0, 12'sd392, 12'sd724, 12'sd946};

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Sample stream, FFT handshake and status bundle of the frame sequencer.
// master drives stimulus and the FFT done level; slave is the sequencer itself.
interface fft_frame_sequencer_if
   import fft_frame_sequencer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int N     = N_DEF
);
   logic                      enable;
   logic [WIDTH-1:0]          sample_in;
   logic                      sample_valid;
   logic                      clear_err;
   logic                      fft_start;
   logic                      fft_done;
   logic [N-1:0][WIDTH-1:0]   fft_samples;
   logic                      frame_valid;
   logic [15:0]               frame_count;
   logic                      busy;
   logic                      overrun;
   logic                      timeout_err;

   modport master (
      output enable, sample_in, sample_valid, clear_err, fft_done,
      input  fft_start, fft_samples, frame_valid, frame_count, busy, overrun, timeout_err
   );

   modport slave (
      input  enable, sample_in, sample_valid, clear_err, fft_done,
      output fft_start, fft_samples, frame_valid, frame_count, busy, overrun, timeout_err
   );
endinterface

// File: rtl/fft_frame_sequencer_frame_buffer_pp.sv
// Ping-pong frame buffer: two banks of N samples filled in turn, read bank
// exposed whole to the FFT and handed back by a one-cycle release.
module fft_frame_sequencer_frame_buffer_pp
   import fft_frame_sequencer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int N     = N_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en_i,
   input  logic [WIDTH-1:0]        wr_data_i,
   input  logic                    release_i,
   output logic                    rd_full_o,
   output logic                    drop_o,
   output logic [N-1:0][WIDTH-1:0] rd_data_o
);
   localparam int PTR_W = $clog2(N);

   logic [1:0][N-1:0][WIDTH-1:0] bank_q;
   logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
   logic                         wr_bank_q, wr_bank_d;
   logic                         rd_bank_q, rd_bank_d;
   logic [1:0]                   full_q, full_d;
   logic                         accept;

   // Writes judge the registered flags, so a bank released this cycle still drops
   assign accept    = wr_en_i & ~full_q[wr_bank_q];
   assign drop_o    = wr_en_i &  full_q[wr_bank_q];
   assign rd_full_o = full_q[rd_bank_q];
   assign rd_data_o = bank_q[rd_bank_q];

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      full_d    = full_q;
      if (accept) begin
         if (wr_ptr_q == PTR_W'(N-1)) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_ptr_d          = '0;
         end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
      end
      if (release_i) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bank_q    <= '0;
         wr_ptr_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         full_q    <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         full_q    <= full_d;
         if (accept) bank_q[wr_bank_q][wr_ptr_q] <= wr_data_i;
      end
   end
endmodule

// File: rtl/fft_frame_sequencer.sv
// FFT front-end sequencer: launches a transform per completed frame, guards
// the done handshake with a timeout, and keeps frame count and sticky errors.
module fft_frame_sequencer
   import fft_frame_sequencer_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int N       = N_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   fft_frame_sequencer_if.slave bus
);
   localparam int CNT_W = $clog2(TIMEOUT);

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [15:0]      frame_count_q, frame_count_d;
   logic             overrun_q, overrun_d;
   logic             timeout_q, timeout_d;
   logic             rd_full, drop, release_bank, timed_out;

   fft_frame_sequencer_frame_buffer_pp #(.WIDTH(WIDTH), .N(N)) u_fbuf (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (bus.enable & bus.sample_valid),
      .wr_data_i (bus.sample_in),
      .release_i (release_bank),
      .rd_full_o (rd_full),
      .drop_o    (drop),
      .rd_data_o (bus.fft_samples)
   );

   // wait_cnt_q holds the number of WAIT cycles already completed
   assign timed_out = (wait_cnt_q == CNT_W'(TIMEOUT-1));

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      frame_count_d = frame_count_q;
      release_bank  = 1'b0;
      overrun_d     = overrun_q & ~bus.clear_err;
      timeout_d     = timeout_q & ~bus.clear_err;
      case (state_q)
         IDLE: if (bus.enable & rd_full) state_d = START;
         START: begin
            state_d    = WAIT;
            wait_cnt_d = '0;
         end
         WAIT: begin
            if (bus.fft_done) begin
               release_bank  = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
               state_d       = IDLE;
            end else if (timed_out) begin
               release_bank = 1'b1;
               timeout_d    = 1'b1;
               state_d      = IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (drop) overrun_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         wait_cnt_q    <= '0;
         frame_count_q <= '0;
         overrun_q     <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         frame_count_q <= frame_count_d;
         overrun_q     <= overrun_d;
         timeout_q     <= timeout_d;
      end
   end

   assign bus.fft_start   = (state_q == START);
   assign bus.busy        = (state_q != IDLE);
   assign bus.frame_valid = (state_q == WAIT) & bus.fft_done;
   assign bus.frame_count = frame_count_q;
   assign bus.overrun     = overrun_q;
   assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed and randomized bench for fft_frame_sequencer against a frame-level
// model: every sample presented while enabled lands in order, N per frame.
module tb_fft_frame_sequencer;
   import fft_frame_sequencer_pkg::*;

   localparam int W  = WIDTH_DEF;
   localparam int NS = N_DEF;
   localparam int FW = NS * W;
   typedef logic [NS-1:0][W-1:0] frame_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fft_frame_sequencer_if #(.WIDTH(W), .N(NS)) b1 ();
   fft_frame_sequencer_if #(.WIDTH(W), .N(NS)) b2 ();

   fft_frame_sequencer #(.WIDTH(W), .N(NS), .TIMEOUT(8))  dut      (.clk(clk), .rst(rst), .bus(b1));
   fft_frame_sequencer #(.WIDTH(W), .N(NS), .TIMEOUT(64)) dut_long (.clk(clk), .rst(rst), .bus(b2));

   int n_assert = 0;
   int n_fail   = 0;

   // FFT behaviour: done falls when start is seen, rises in WAIT cycle fft_delay (0 = never)
   int   fft_delay  = 3;
   int   age        = 0;
   logic mdl_done   = 1'b0;
   logic force_done = 1'b0;
   always @(posedge clk) begin
      if (!rst) begin
         mdl_done <= 1'b0;
         age      <= 0;
      end else if (b1.fft_start) begin
         age      <= 1;
         mdl_done <= (fft_delay == 1);
      end else if (age > 0) begin
         age      <= age + 1;
         mdl_done <= (fft_delay > 0) && (age + 1 >= fft_delay);
      end
   end
   assign b1.fft_done = mdl_done | force_done;

   frame_t got[$];
   int     fv_cnt = 0;
   always @(negedge clk) begin
      if (rst) begin
         if (b1.fft_start) got.push_back(b1.fft_samples);
         if (b1.frame_valid) fv_cnt++;
      end
   end

   int     acc[$];
   frame_t exp_q[$];

   function automatic void accept_sample(input int v);
      frame_t f;
      acc.push_back(v);
      if (acc.size() == NS) begin
         for (int k = 0; k < NS; k++) f[k] = W'(acc[k]);
         exp_q.push_back(f);
         acc.delete();
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send1(input int v, input logic en);
      b1.sample_in    = W'(v);
      b1.sample_valid = 1'b1;
      b1.enable       = en;
      if (en) accept_sample(v);
      tick();
   endtask

   task automatic send2(input int v);
      b2.sample_in    = W'(v);
      b2.sample_valid = 1'b1;
      b2.enable       = 1'b1;
      tick();
   endtask

   task automatic wait_count(input string tag, input int target, input int budget);
      int i = 0;
      while (b1.frame_count != 16'(target) && i < budget) begin
         tick();
         i++;
      end
      chk(tag, FW'(b1.frame_count), FW'(target));
   endtask

   task automatic check_frames(input string tag);
      chk({tag, "_nframes"}, FW'(got.size()), FW'(exp_q.size()));
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_frame%0d", tag, i), got[i], exp_q[i]);
      got.delete();
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_t fr;
      int     nfr;
      b1.enable = 1'b0; b1.sample_in = '0; b1.sample_valid = 1'b0; b1.clear_err = 1'b0;
      b2.enable = 1'b0; b2.sample_in = '0; b2.sample_valid = 1'b0; b2.clear_err = 1'b0;
      b2.fft_done = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_start",   FW'(b1.fft_start),   FW'(0));
      chk("rst_busy",    FW'(b1.busy),        FW'(0));
      chk("rst_fvalid",  FW'(b1.frame_valid), FW'(0));
      chk("rst_count",   FW'(b1.frame_count), FW'(0));
      chk("rst_overrun", FW'(b1.overrun),     FW'(0));
      chk("rst_timeout", FW'(b1.timeout_err), FW'(0));
      chk("rst_samples", b1.fft_samples,      FW'(0));
      rst = 1'b1;
      tick();

      // Single frame 1..16, start latency and done after 3 WAIT cycles
      fv_cnt = 0;
      for (int i = 0; i < NS; i++) send1(i + 1, 1'b1);
      b1.sample_valid = 1'b0;
      chk("t1_start_early", FW'(b1.fft_start), FW'(0));
      tick();
      chk("t1_start", FW'(b1.fft_start), FW'(1));
      for (int k = 0; k < NS; k++) fr[k] = W'(k + 1);
      chk("t1_samples", b1.fft_samples, fr);
      tick();
      chk("t1_start_once", FW'(b1.fft_start), FW'(0));
      chk("t1_busy", FW'(b1.busy), FW'(1));
      wait_count("t1_count", 1, 20);
      chk("t1_fvalid_pulses", FW'(fv_cnt), FW'(1));
      check_frames("t1");

      // Continuous stream of four frames
      fv_cnt = 0;
      for (int i = 0; i < 4 * NS; i++) send1(int'($urandom_range(0, 4095)), 1'b1);
      b1.sample_valid = 1'b0;
      wait_count("t2_count", 5, 60);
      chk("t2_fvalid_pulses", FW'(fv_cnt), FW'(4));
      chk("t2_overrun", FW'(b1.overrun), FW'(0));
      check_frames("t2");

      // FFT never finishes: timeout on the 8th WAIT cycle, then clear
      fft_delay = 0;
      fv_cnt = 0;
      for (int i = 0; i < NS; i++) send1(int'($urandom_range(0, 4095)), 1'b1);
      b1.sample_valid = 1'b0;
      tick();
      chk("t3_start", FW'(b1.fft_start), FW'(1));
      repeat (8) tick();
      chk("t3_busy_wait8", FW'(b1.busy), FW'(1));
      chk("t3_no_timeout_yet", FW'(b1.timeout_err), FW'(0));
      tick();
      chk("t3_timeout", FW'(b1.timeout_err), FW'(1));
      chk("t3_idle", FW'(b1.busy), FW'(0));
      chk("t3_count", FW'(b1.frame_count), FW'(5));
      chk("t3_no_fvalid", FW'(fv_cnt), FW'(0));
      b1.clear_err = 1'b1;
      tick();
      b1.clear_err = 1'b0;
      chk("t3_cleared", FW'(b1.timeout_err), FW'(0));
      check_frames("t3");

      // Long transform on the second instance: both banks fill, overflow drops
      for (int i = 0; i < 36; i++) begin
         send2(100 + i);
         if (i == 31) chk("t4_no_overrun", FW'(b2.overrun), FW'(0));
         if (i == 32) chk("t4_overrun", FW'(b2.overrun), FW'(1));
      end
      b2.sample_valid = 1'b0;
      for (int k = 0; k < NS; k++) fr[k] = W'(100 + k);
      chk("t4_frame_a_held", b2.fft_samples, fr);
      repeat (20) tick();
      b2.fft_done = 1'b1;
      #1;
      chk("t4_fvalid", FW'(b2.frame_valid), FW'(1));
      tick();
      b2.fft_done = 1'b0;
      chk("t4_count1", FW'(b2.frame_count), FW'(1));
      chk("t4_no_timeout", FW'(b2.timeout_err), FW'(0));
      for (int k = 0; k < NS; k++) fr[k] = W'(116 + k);
      chk("t4_frame_b", b2.fft_samples, fr);
      for (int i = 0; i < NS; i++) send2(200 + i);
      b2.sample_valid = 1'b0;
      chk("t4_overrun_sticky", FW'(b2.overrun), FW'(1));
      b2.fft_done = 1'b1;
      tick();
      b2.fft_done = 1'b0;
      chk("t4_count2", FW'(b2.frame_count), FW'(2));
      for (int k = 0; k < NS; k++) fr[k] = W'(200 + k);
      chk("t4_frame_c", b2.fft_samples, fr);
      repeat (3) tick();
      b2.fft_done = 1'b1;
      tick();
      b2.fft_done = 1'b0;
      chk("t4_count3", FW'(b2.frame_count), FW'(3));
      b2.clear_err = 1'b1;
      tick();
      b2.clear_err = 1'b0;
      b2.enable = 1'b0;
      chk("t4_overrun_cleared", FW'(b2.overrun), FW'(0));

      // Enable gap inside a frame: 10 in, 5 ignored, 6 in
      fft_delay = 3;
      for (int i = 0; i < 10; i++) send1(int'($urandom_range(0, 4095)), 1'b1);
      for (int i = 0; i < 5; i++) send1(int'($urandom_range(0, 4095)), 1'b0);
      chk("t5_idle_disabled", FW'(b1.busy), FW'(0));
      chk("t5_no_overrun_disabled", FW'(b1.overrun), FW'(0));
      for (int i = 0; i < 6; i++) send1(int'($urandom_range(0, 4095)), 1'b1);
      b1.sample_valid = 1'b0;
      wait_count("t5_count", 6, 20);
      chk("t5_overrun", FW'(b1.overrun), FW'(0));
      check_frames("t5");

      // Randomized enable/valid traffic with random FFT latency
      fft_delay = int'($urandom_range(1, 4));
      fv_cnt = 0;
      for (int c = 0; c < 300; c++) begin
         logic en;
         en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) != 0) send1(int'($urandom_range(0, 4095)), en);
         else begin
            b1.sample_valid = 1'b0;
            b1.enable = en;
            tick();
         end
      end
      while (acc.size() != 0) send1(int'($urandom_range(0, 4095)), 1'b1);
      b1.sample_valid = 1'b0;
      b1.enable = 1'b1;
      nfr = exp_q.size();
      wait_count("rnd_count", 6 + nfr, 60);
      chk("rnd_fvalid_pulses", FW'(fv_cnt), FW'(nfr));
      chk("rnd_overrun", FW'(b1.overrun), FW'(0));
      check_frames("rnd");

      // Reset asserted during WAIT
      fft_delay = 0;
      for (int i = 0; i < NS; i++) send1(int'($urandom_range(1, 4095)), 1'b1);
      b1.sample_valid = 1'b0;
      tick();
      tick();
      chk("t6_busy_wait", FW'(b1.busy), FW'(1));
      #2 rst = 1'b0;
      #1;
      chk("t6_busy", FW'(b1.busy), FW'(0));
      chk("t6_start", FW'(b1.fft_start), FW'(0));
      chk("t6_count", FW'(b1.frame_count), FW'(0));
      chk("t6_samples", b1.fft_samples, FW'(0));
      chk("t6_overrun", FW'(b1.overrun), FW'(0));
      chk("t6_timeout", FW'(b1.timeout_err), FW'(0));
      tick();
      rst = 1'b1;
      force_done = 1'b1;
      #1;
      chk("t6_fvalid_ignored", FW'(b1.frame_valid), FW'(0));
      repeat (3) tick();
      force_done = 1'b0;
      chk("t6_count_after", FW'(b1.frame_count), FW'(0));
      chk("t6_idle_after", FW'(b1.busy), FW'(0));
      got.delete();
      exp_q.delete();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Front-end controller for the 16-point FFT datapath. Collects a streaming audio sample sequence into a ping-pong frame buffer and hands each completed frame to the FFT. Issues the one-cycle `start`, holds the frame stable for the whole transform, and watches `done` with a timeout. Publishes a frame-valid strobe so downstream display logic can sample the FFT's frequency outputs.

## Interface
- `WIDTH`, 12, sample width in bits (unsigned, matches FFT `time_samples`)
- `N`, 16, frame length; power of 4
- `TIMEOUT`, 8, max cycles in WAIT before declaring the FFT hung; ≥ 4
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `enable`  in  1  1 = accept samples and launch transforms
- `sample_in`  in  WIDTH  incoming sample
- `sample_valid`  in  1  `sample_in` valid this cycle
- `clear_err`  in  1  clears sticky error flags
- `fft_start`  out  1  one-cycle start pulse to FFT
- `fft_done`  in  1  FFT done level from FFT
- `fft_samples`  out  WIDTH×N  frame presented to FFT `time_samples`
- `frame_valid`  out  1  FFT frequency outputs valid at the rising edge ending this cycle
- `frame_count`  out  16  completed transforms, wraps modulo 2^16
- `busy`  out  1  FSM not in IDLE
- `overrun`  out  1  sticky: a valid sample was dropped
- `timeout_err`  out  1  sticky: FFT failed to report done

## Operation
- Two banks of N samples; write pointer `wr_ptr` (log2 N bits), write bank `wr_bank`, read bank `rd_bank`, flags `full[1:0]`.
- Write: when `enable & sample_valid`, check registered `full[wr_bank]`.
  - If clear: store at `bank[wr_bank][wr_ptr]`, increment `wr_ptr`.
  - When `wr_ptr == N-1` is written: set `full[wr_bank]`, toggle `wr_bank`, `wr_ptr` returns to 0.
  - If set: drop the sample and set `overrun`.
- `enable = 0`: samples are ignored, without setting `overrun`. A partial fill keeps its pointer. A transform in flight completes, but no new start is issued.
- FSM states: IDLE, START, WAIT.
  - IDLE → START when `enable & full[rd_bank]`.
  - START → WAIT unconditionally.
  - WAIT → IDLE on `fft_done`: release the bank and increment `frame_count`.
  - WAIT → IDLE when the WAIT cycle count reaches TIMEOUT without `fft_done`: set `timeout_err`, release the bank, leave `frame_count` unchanged.
- Release: clear `full[rd_bank]` and toggle `rd_bank`. Banks are therefore transformed strictly in fill order 0, 1, 0, ….
- `fft_samples` = `bank[rd_bank]`. It changes only on release, so it is stable from START through WAIT.
- `fft_start = (state == START)`; `busy = (state != IDLE)`.
- `frame_valid = (state == WAIT) & fft_done`. This is the only combinational output.
- `fft_done` outside WAIT is ignored.
- Same-cycle cases:
  - Release and a write to that bank in the same cycle: the write sees the pre-release `full` value, so the sample is dropped and `overrun` is set.
  - `clear_err` with a new error event in the same cycle: the set wins.

## Timing
- Reset values: every output 0, FSM in IDLE, both banks zeroed, `wr_ptr`, `wr_bank`, `rd_bank`, `full` all 0.
- Reset asserted mid-transform: everything returns to reset values immediately, and the frame is lost.
- Start latency: the final sample of a frame is captured at edge t. With FSM in IDLE and `enable = 1`, `fft_start` is high in the cycle after edge t+1, for exactly one cycle.
- `frame_valid` pulses in the cycle `fft_done` is seen in WAIT. The next frame's `fft_start` can come no earlier than 2 cycles after that.
- Timeout fires on the TIMEOUT-th consecutive WAIT cycle without `fft_done`. The counter resets on entry to WAIT.
- Sustained throughput: one sample per cycle is lossless only if a transform plus 2 overhead cycles takes ≤ N cycles. With the current FFT this is 5 ≤ 16.

## Structure
- Shared `fft_pkg`:
  - `seq_state_t` enum {IDLE, START, WAIT}
  - default `N`, `WIDTH` constants
  - the twiddle ROM constants also used by the FFT
- Sub-module `frame_buffer_pp`: the two banks, write pointer/bank logic, `full` flags, and the `rd_bank` mux. The release input comes from the FSM.
- FSM, timeout counter, `frame_count`, and sticky flags stay in the top module.

## Test plan
- Reset, then 16 samples 1..16 on consecutive cycles → `fft_start` one cycle, 2 edges after sample 16. `fft_samples[k] = k+1`. With the FFT model returning done after 3 cycles → `frame_valid` once, `frame_count = 1`.
- Continuous stream of 64 samples → 4 transforms in bank order 0, 1, 0, 1. `frame_count = 4`, `overrun = 0`.
- FFT model never asserts done → `timeout_err` set on the 8th WAIT cycle, FSM back to IDLE, `frame_count` unchanged. Then `clear_err` → `timeout_err = 0`.
- FFT done delayed 40 cycles with a continuous stream → both banks fill, the next sample is dropped, `overrun = 1`. After release, writing resumes at `wr_ptr = 0` of the released bank.
- `enable = 0` after 10 samples, with 5 more samples presented → no writes, no `overrun`. Re-enable and send 6 samples → the frame completes with the first 10 plus the last 6 samples.
- `rst` low during WAIT → all outputs 0 immediately. A later `fft_done` is ignored.
